// File: rtl/product_bcd_pkg.sv
// Shared definitions for the product_bcd binary-to-BCD converter.
// Holds the operand/result widths, the last iteration index and the
// FSM state encoding used by the top level and its debug port.
package product_bcd_pkg;

    localparam int BIN_W      = 16;
    localparam int BCD_DIGITS = 5;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int CNT_W      = 4;

    // Counter runs 0..ITER_LAST, one double-dabble iteration per value.
    localparam logic [CNT_W-1:0] ITER_LAST = 4'd15;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } stateT;

endpackage

// File: rtl/product_bcd_digit_adjust.sv
// Combinational double-dabble digit correction.
// Ports:
//   digitIn  - one BCD digit before the shift
//   digitOut - digitIn + 3 when digitIn >= 5, otherwise digitIn unchanged
// Adding 3 before the left shift makes a digit of 5..9 carry into the next
// digit instead of becoming an invalid 10..19 code.
module bcd_digit_adjust (
    input  logic [3:0] digitIn,
    output logic [3:0] digitOut
);

    assign digitOut = (digitIn >= 4'd5) ? (digitIn + 4'd3) : digitIn;

endmodule

// File: rtl/product_bcd.sv
// Sequential 16-bit binary to 5-digit BCD converter (double dabble).
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst      - synchronous active-high reset
//   start    - conversion request, only looked at while idle
//   bin      - unsigned 16-bit operand, captured on the accepted start
//   busy     - high while a conversion is in progress
//   done     - one-cycle pulse, bcd carries a fresh result in that cycle
//   bcd      - five packed BCD digits, [19:16] ten-thousands .. [3:0] units
//   dbgState - current FSM state, for observation only
//
// Handshake: start acts as a request that is accepted on any rising edge
// where the block is idle (busy=0) and rst is low; requests while busy are
// dropped, not queued. Exactly 16 edges after acceptance done pulses for one
// cycle together with the new bcd value, and busy falls in that same cycle,
// so a start held during the done cycle is accepted on the next edge.
module product_bcd
    import product_bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd,
    output stateT            dbgState
);

    stateT            state;
    stateT            stateNext;
    logic [BIN_W-1:0] shiftReg;
    logic [BCD_W-1:0] digits;
    logic [BCD_W-1:0] adjDigits;
    logic [BCD_W-1:0] nextDigits;
    logic [CNT_W-1:0] cnt;
    logic             lastIter;

    for (genvar i = 0; i < BCD_DIGITS; i++) begin : gAdj
        bcd_digit_adjust uAdj (
            .digitIn (digits[4*i +: 4]),
            .digitOut(adjDigits[4*i +: 4])
        );
    end

    // Adjusted digits shifted left once, next operand MSB enters the units LSB.
    assign nextDigits = {adjDigits[BCD_W-2:0], shiftReg[BIN_W-1]};
    assign lastIter   = (cnt == ITER_LAST);

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start)    stateNext = SHIFT;
            SHIFT:   if (lastIter) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shiftReg <= '0;
            digits   <= '0;
            cnt      <= '0;
            bcd      <= '0;
            done     <= 1'b0;
        end else begin
            state <= stateNext;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shiftReg <= bin;
                        digits   <= '0;
                        cnt      <= '0;
                    end
                end
                SHIFT: begin
                    digits   <= nextDigits;
                    shiftReg <= {shiftReg[BIN_W-2:0], 1'b0};
                    cnt      <= cnt + 1'b1;
                    // Only the final iteration is published, so bcd never
                    // shows partially converted digits.
                    if (lastIter) begin
                        bcd  <= nextDigits;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state == SHIFT);
    assign dbgState = state;

endmodule
